// File: rtl/gate_apply_engine.sv
// Applies a 2x2 complex gate to one qubit of an N-amplitude state held in external memory.
// Build option: define GATE_SAT_EN to saturate instead of wrap on fixed-point overflow.
module gate_apply_engine #(
  parameter int N      = 2,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [((N > 2) ? $clog2(N) : 1)-1:0]  target,
  input  logic [2*DATA_W-1:0]                   u00,
  input  logic [2*DATA_W-1:0]                   u01,
  input  logic [2*DATA_W-1:0]                   u10,
  input  logic [2*DATA_W-1:0]                   u11,
  input  logic [2*DATA_W-1:0]                   mem_rdata,
  output logic [((N > 2) ? $clog2(N) : 1)-1:0]  mem_addr,
  output logic [2*DATA_W-1:0]                   mem_wdata,
  output logic                                  mem_wen,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  cfg_err
);

  localparam int QB    = $clog2(N);
  localparam int TW    = (N > 2) ? QB : 1;
  localparam int CW    = 2 * DATA_W;
  localparam int ACC_W = 2 * DATA_W + 2;
  localparam logic [TW-1:0] K_LAST = TW'(N / 2 - 1);

  // Handshake: start is a level sampled only in IDLE; no backpressure. done and
  // cfg_err are one-cycle pulses; busy covers RD0..WR1 of an accepted operation.
  typedef enum logic [2:0] {IDLE, RD0, RD1, CALC, WR0, WR1, FIN} state_t;
  state_t state, state_nx;

  logic [TW-1:0] tgt_q, k;
  logic [CW-1:0] g00, g01, g10, g11;
  logic [CW-1:0] a0, a1, b0, b1;
  logic          cfg_err_q;
  logic          target_ok;
  logic [TW-1:0] lo_mask, i0, i1;

  assign target_ok = ({1'b0, target} < (TW + 1)'(QB));

`ifdef GATE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  function automatic logic signed [ACC_W-1:0] mulx(input logic signed [DATA_W-1:0] p,
                                                   input logic signed [DATA_W-1:0] q);
    logic signed [CW-1:0] prod;
    prod = p * q;
    return $signed({{(ACC_W - CW){prod[CW-1]}}, prod});
  endfunction

  // Floor shift back to the component format, then wrap or clamp to DATA_W.
  function automatic logic [DATA_W-1:0] reduce(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] q;
    logic [DATA_W-1:0]       r;
    q = s >>> FRAC_W;
    r = q[DATA_W-1:0];
`ifdef GATE_SAT_EN
    if (q > SAT_MAX)      r = {1'b0, {(DATA_W - 1){1'b1}}};
    else if (q < SAT_MIN) r = {1'b1, {(DATA_W - 1){1'b0}}};
`endif
    return r;
  endfunction

  function automatic logic [CW-1:0] cmac(input logic [CW-1:0] ua, input logic [CW-1:0] xa,
                                         input logic [CW-1:0] ub, input logic [CW-1:0] xb);
    logic signed [ACC_W-1:0] re_s, im_s;
    re_s = mulx(ua[CW-1:DATA_W], xa[CW-1:DATA_W]) - mulx(ua[DATA_W-1:0], xa[DATA_W-1:0])
         + mulx(ub[CW-1:DATA_W], xb[CW-1:DATA_W]) - mulx(ub[DATA_W-1:0], xb[DATA_W-1:0]);
    im_s = mulx(ua[CW-1:DATA_W], xa[DATA_W-1:0]) + mulx(ua[DATA_W-1:0], xa[CW-1:DATA_W])
         + mulx(ub[CW-1:DATA_W], xb[DATA_W-1:0]) + mulx(ub[DATA_W-1:0], xb[CW-1:DATA_W]);
    return {reduce(re_s), reduce(im_s)};
  endfunction

  // Insert a zero at bit tgt_q of the pair counter to get the lower index.
  always_comb begin
    lo_mask = (TW'(1) << tgt_q) - TW'(1);
    i0      = (k & lo_mask) | ((k & ~lo_mask) << 1);
    i1      = i0 | (TW'(1) << tgt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && target_ok) state_nx = RD0;
      RD0:     state_nx = RD1;
      RD1:     state_nx = CALC;
      CALC:    state_nx = WR0;
      WR0:     state_nx = WR1;
      WR1:     state_nx = (k == K_LAST) ? FIN : RD0;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q     <= '0;
      k         <= '0;
      g00       <= '0;
      g01       <= '0;
      g10       <= '0;
      g11       <= '0;
      a0        <= '0;
      a1        <= '0;
      b0        <= '0;
      b1        <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state == IDLE) && start && !target_ok;
      case (state)
        IDLE: begin
          if (start && target_ok) begin
            tgt_q <= target;
            g00   <= u00;
            g01   <= u01;
            g10   <= u10;
            g11   <= u11;
            k     <= '0;
          end
        end
        RD0:  a0 <= mem_rdata;
        RD1:  a1 <= mem_rdata;
        CALC: begin
          b0 <= cmac(g00, a0, g01, a1);
          b1 <= cmac(g10, a0, g11, a1);
        end
        WR1:  if (k != K_LAST) k <= k + TW'(1);
        default: ;
      endcase
    end
  end

  // Memory port decoded from state so reset silences writes immediately.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    case (state)
      RD0: mem_addr = i0;
      RD1: mem_addr = i1;
      WR0: begin
        mem_addr  = i0;
        mem_wdata = b0;
        mem_wen   = 1'b1;
      end
      WR1: begin
        mem_addr  = i1;
        mem_wdata = b1;
        mem_wen   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state != IDLE) && (state != FIN);
  assign done    = (state == FIN);
  assign cfg_err = cfg_err_q;

endmodule
